// File: rtl/rgb_pwm_latch_pkg.sv
// Shared constants for the RGB switch-latch block: channel count, channel
// indices and a constant clog2 used to size counters.
package rgb_pkg;

    localparam int N_CH = 3;
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rgb_pwm_latch_if.sv
// Board-side bundle of the RGB latch: button, switches and mode in,
// LED drive, latched levels and load strobe out.
interface rgb_pwm_latch_if #(
    parameter int CH_BITS = 2
);
    import rgb_pkg::*;

    logic                      btn;
    logic [N_CH*CH_BITS-1:0]   sw;
    logic                      pwm_en;
    logic [N_CH-1:0]           rgb;
    logic [N_CH*CH_BITS-1:0]   level;
    logic                      load_pulse;

    modport master (
        output btn, sw, pwm_en,
        input  rgb, level, load_pulse
    );

    modport slave (
        input  btn, sw, pwm_en,
        output rgb, level, load_pulse
    );

endinterface

// File: rtl/rgb_pwm_latch_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, counter debouncer and rising-edge
// detector. Reusable for any raw board push-button.
module btn_debounce
    import rgb_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic db_state,
    output logic rise
);

    localparam int            CW      = clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_db_state;
    logic          r_db_prev;

    // NOTE: every register uses <= so all stages sample pre-edge values; a
    // blocking assignment here would collapse the synchroniser into one FF.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_cnt      <= '0;
            r_db_state <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_s1      <= btn_raw;
            r_s2      <= r_s1;
            r_db_prev <= r_db_state;
            if (r_s2 == r_db_state) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_db_state <= r_s2;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign db_state = r_db_state;
    assign rise     = r_db_state & ~r_db_prev;

endmodule

// File: rtl/rgb_pwm_latch.sv
// Switch-to-RGB stage: a debounced press latches the switch bank as
// per-channel levels, which drive the LEDs statically or through PWM.
module rgb_pwm_latch
    import rgb_pkg::*;
#(
    parameter int CH_BITS   = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic           clk,
    input  logic           clr,
    rgb_pwm_latch_if.slave bus
);

    localparam int LW = N_CH * CH_BITS;

    logic               w_rise;
    logic [CH_BITS-1:0] w_lvl      [N_CH];
    logic [N_CH-1:0]    w_rgb_next;

    logic [LW-1:0]      r_level;
    logic               r_load_pulse;
    logic [CH_BITS-1:0] r_pwm_cnt;
    logic [N_CH-1:0]    r_rgb;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .clr      (clr),
        .btn_raw  (bus.btn),
        .db_state (),
        .rise     (w_rise)
    );

    // Channel i drives rgb[i]; continuous assigns keep this free of latches.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_lvl[i]      = r_level[i*CH_BITS +: CH_BITS];
        assign w_rgb_next[i] = bus.pwm_en ? (w_lvl[i] > r_pwm_cnt) : (|w_lvl[i]);
    end

    // NOTE: reset is synchronous, so clr only acts on a clock edge and
    // overrides a coincident load in the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_level      <= '0;
            r_load_pulse <= 1'b0;
            r_pwm_cnt    <= '0;
            r_rgb        <= '0;
        end else begin
            r_load_pulse <= w_rise;
            if (w_rise) begin
                r_level <= bus.sw;
            end
            r_pwm_cnt <= r_pwm_cnt + CH_BITS'(1);
            r_rgb     <= w_rgb_next;
        end
    end

    assign bus.level      = r_level;
    assign bus.load_pulse = r_load_pulse;
    assign bus.rgb        = r_rgb;

endmodule
